// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: shared FSM state encoding, the NOP instruction word,
// the default reset PC and the access-size alignment helper used by the
// optional SEQ_MISALIGN_TRAP_EN build of core_sequencer.
package core_sequencer_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } seq_state_e;

   localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Alignment check keyed on funct3[1:0]: 00 byte, 01 half, 10/11 word.
   function automatic logic ls_misaligned(input logic [1:0] addr_lo,
                                          input logic [1:0] size);
      logic bad;
      bad = 1'b0;
      unique case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = addr_lo[0];
         default: bad = (addr_lo != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/seq_next_pc.sv
// seq_next_pc: combinational selector of the address of the next instruction.
// Sums wrap modulo 2^32; jalr targets have bit 0 forced to zero.
module seq_next_pc (
   input  logic [31:0] pc,
   input  logic        jal,
   input  logic        jalr,
   input  logic        branch,
   input  logic        br_taken,
   input  logic [31:0] jal_offset,
   input  logic [31:0] jalr_offset,
   input  logic [31:0] branch_offset,
   input  logic [31:0] qa,
   output logic [31:0] next_pc
);

   // Jumps take priority over branches; everything else falls through to pc+4.
   always_comb begin
      next_pc = pc + 32'd4;
      if (jal) begin
         next_pc = pc + jal_offset;
      end else if (jalr) begin
         next_pc = (qa + jalr_offset) & ~32'd1;
      end else if (branch && br_taken) begin
         next_pc = pc + branch_offset;
      end
   end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a
// bus-wait timeout that halts the core with a sticky err.
// Optional build macro SEQ_MISALIGN_TRAP_EN: misaligned fetches and load/store
// addresses trap to HALT with err set, before any memory request is issued.
module core_sequencer
   import core_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jal,
   input  logic        jalr,
   input  logic        branch,
   input  logic        load,
   input  logic        store,
   input  logic [31:0] jal_offset,
   input  logic [31:0] jalr_offset,
   input  logic [31:0] branch_offset,
   input  logic [31:0] qa,
   input  logic        br_taken,
   input  logic [31:0] alu_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] pc,
   output logic [31:0] ir,
   output logic        rf_we,
   output logic        err
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   seq_state_e        state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              err_q, err_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [31:0]       addr_q, addr_d;
   logic              taken_q, taken_d;
   logic [31:0]       next_pc;
   logic              wait_hit;
   logic              fetch_misalign;
   logic              ls_misalign;

`ifdef SEQ_MISALIGN_TRAP_EN
   assign fetch_misalign = (pc_q[1:0] != 2'b00);
   assign ls_misalign    = (load || store) && ls_misaligned(alu_data[1:0], ir_q[13:12]);
`else
   assign fetch_misalign = 1'b0;
   assign ls_misalign    = 1'b0;
`endif

   // The cycle that would be the MEM_TIMEOUT-th stalled cycle of a request.
   assign wait_hit = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   // Branch outcome is captured in EXEC so WB does not depend on the ALU later.
   seq_next_pc u_next_pc (
      .pc            (pc_q),
      .jal           (jal),
      .jalr          (jalr),
      .branch        (branch),
      .br_taken      (taken_q),
      .jal_offset    (jal_offset),
      .jalr_offset   (jalr_offset),
      .branch_offset (branch_offset),
      .qa            (qa),
      .next_pc       (next_pc)
   );

   // Next-state and Moore outputs; reset forces the bus and write strobe low.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      err_d    = err_q;
      wait_d   = wait_q;
      addr_d   = addr_q;
      taken_d  = taken_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = pc_q;
      rf_we    = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (fetch_misalign) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_d    = mem_rdata;
                  wait_d  = '0;
                  state_d = DECODE;
               end else if (wait_hit) begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         DECODE: begin
            state_d = EXEC;
         end
         EXEC: begin
            taken_d = br_taken;
            wait_d  = '0;
            if (load || store) begin
               if (ls_misalign) begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  addr_d  = alu_data;
                  state_d = MEM;
               end
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            mem_req  = 1'b1;
            mem_we   = store;
            mem_addr = addr_q;
            if (mem_ready) begin
               wait_d  = '0;
               state_d = WB;
            end else if (wait_hit) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         WB: begin
            rf_we   = !(branch || store);
            pc_d    = next_pc;
            state_d = FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = HALT;
         end
      endcase
      if (!rst_n) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         rf_we   = 1'b0;
      end
   end

   // State registers; the latched effective address is pure data and not reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= NOP_INSN;
         err_q   <= 1'b0;
         wait_q  <= '0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
         taken_q <= taken_d;
      end
      addr_q <= addr_d;
   end

   assign pc  = pc_q;
   assign ir  = ir_q;
   assign err = err_q;

endmodule
